// File: rtl/sad_eval_pkg.sv
// Shared types and default widths for the SAD error-evaluation harness.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sad_eval_pkg;

    localparam int N_IN_DEF  = 10;
    localparam int N_OUT_DEF = 3;

    // Accumulator widths for the default netlist size. A full sweep of
    // 2^N_IN vectors, each with error up to 2^N_OUT-1, fits in SUM_W bits.
    // err_count can reach exactly 2^N_IN, which needs one extra bit.
    localparam int SUM_W = N_IN_DEF + N_OUT_DEF;
    localparam int CNT_W = N_IN_DEF + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sad_err_accum.sv
// Error accumulator: |exact-approx|, threshold count, sum, worst case + first vector hitting it.
// Latency: results register one cycle after a valid sample.
// Backpressure: none; every valid sample is absorbed. clear has priority over valid.
// Ports: clk, rst_n, clear, valid, tag, exact_po, approx_po in;
//        err_count, sum_abs_err, max_abs_err, wce_vector out (all registered).
module sad_err_accum
    import sad_eval_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_OUT = N_OUT_DEF,
    parameter int ET    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  valid,
    input  logic [N_IN-1:0]       tag,
    input  logic [N_OUT-1:0]      exact_po,
    input  logic [N_OUT-1:0]      approx_po,
    output logic [N_IN:0]         err_count,
    output logic [N_IN+N_OUT-1:0] sum_abs_err,
    output logic [N_OUT-1:0]      max_abs_err,
    output logic [N_IN-1:0]       wce_vector
);

    localparam int          SW   = N_IN + N_OUT;
    localparam int          CW   = N_IN + 1;
    localparam logic [31:0] ET_U = 32'(ET);

    logic [N_OUT-1:0] w_abs_err;
    logic             w_over;

    // Subtract the smaller from the larger so the difference never wraps.
    always_comb begin
        w_abs_err = (exact_po >= approx_po) ? (exact_po - approx_po)
                                            : (approx_po - exact_po);
        w_over    = (32'(w_abs_err) > ET_U);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count   <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
            wce_vector  <= '0;
        end else if (clear) begin
            err_count   <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
            wce_vector  <= '0;
        end else if (valid) begin
            sum_abs_err <= sum_abs_err + SW'(w_abs_err);
            err_count   <= err_count + CW'(w_over);
            // Strict compare: a later tie keeps the earlier vector.
            if (w_abs_err > max_abs_err) begin
                max_abs_err <= w_abs_err;
                wce_vector  <= tag;
            end
        end
    end

endmodule

// File: rtl/sad_error_evaluator.sv
// Exhaustive sweep driver: drives all 2^N_IN vectors to an exact/approx SAD pair and scores the error.
// Latency: done pulses 2^N_IN + DUT_LAT + 1 cycles after the accepted start edge.
// Backpressure: none; start is ignored outside IDLE, results hold until the next accepted start.
// Ports: clk, rst_n, start in; pi out to both netlists; exact_po/approx_po back in;
//        busy, done, err_count, sum_abs_err, max_abs_err, wce_vector out.
module sad_error_evaluator
    import sad_eval_pkg::*;
#(
    parameter int N_IN    = N_IN_DEF,
    parameter int N_OUT   = N_OUT_DEF,
    parameter int DUT_LAT = 0,
    parameter int ET      = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [N_IN-1:0]       pi,
    input  logic [N_OUT-1:0]      exact_po,
    input  logic [N_OUT-1:0]      approx_po,
    output logic                  busy,
    output logic                  done,
    output logic [N_IN:0]         err_count,
    output logic [N_IN+N_OUT-1:0] sum_abs_err,
    output logic [N_OUT-1:0]      max_abs_err,
    output logic [N_IN-1:0]       wce_vector
);

    localparam logic [N_IN-1:0] VEC_MAX    = '1;
    localparam int              DRW        = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;
    localparam logic [DRW-1:0]  DRAIN_LAST = DRW'(DUT_LAT - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N_IN-1:0] r_pi;
    logic [DRW-1:0]  r_drain;
    logic            w_start_acc;
    logic            w_tag_vld;
    logic [N_IN-1:0] w_tag;

    assign w_start_acc = (r_state == ST_IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_RUN;
            // A combinational DUT has nothing in flight, so DRAIN is skipped.
            ST_RUN:   if (r_pi == VEC_MAX) w_state_nxt = (DUT_LAT == 0) ? ST_DONE : ST_DRAIN;
            ST_DRAIN: if (r_drain == DRAIN_LAST) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Vector counter doubles as the pi register. It stops at VEC_MAX and
    // holds through DRAIN/DONE, then returns to 0 for IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pi    <= '0;
            r_drain <= '0;
        end else begin
            case (r_state)
                ST_RUN:   if (r_pi != VEC_MAX) r_pi <= r_pi + 1'b1;
                ST_DRAIN: r_drain <= r_drain + 1'b1;
                default: begin
                    r_pi    <= '0;
                    r_drain <= '0;
                end
            endcase
        end
    end

    assign pi   = r_pi;
    assign busy = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done = (r_state == ST_DONE);

    // Tag pipe matches the netlist latency so each {valid, vec} leaves the
    // pipe in the same cycle as the po words that vector produced.
    generate
        if (DUT_LAT == 0) begin : g_nopipe
            assign w_tag_vld = (r_state == ST_RUN);
            assign w_tag     = r_pi;
        end else begin : g_pipe
            logic [DUT_LAT-1:0]           r_vld;
            logic [DUT_LAT-1:0][N_IN-1:0] r_vec;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld <= '0;
                    r_vec <= '0;
                end else begin
                    r_vld[0] <= (r_state == ST_RUN);
                    r_vec[0] <= r_pi;
                    for (int i = 1; i < DUT_LAT; i++) begin
                        r_vld[i] <= r_vld[i-1];
                        r_vec[i] <= r_vec[i-1];
                    end
                end
            end
            assign w_tag_vld = r_vld[DUT_LAT-1];
            assign w_tag     = r_vec[DUT_LAT-1];
        end
    endgenerate

    sad_err_accum #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .ET    (ET)
    ) u_accum (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (w_start_acc),
        .valid       (w_tag_vld),
        .tag         (w_tag),
        .exact_po    (exact_po),
        .approx_po   (approx_po),
        .err_count   (err_count),
        .sum_abs_err (sum_abs_err),
        .max_abs_err (max_abs_err),
        .wce_vector  (wce_vector)
    );

endmodule

// File: tb/tb_sad_error_evaluator.sv
// Bench for sad_error_evaluator: three instances (LAT0/ET0, LAT0/ET2, LAT2/ET2) swept together.
// Latency: n/a.
// Backpressure: n/a.
module tb_sad_error_evaluator;

    typedef struct packed {
        logic [10:0] cnt;
        logic [12:0] sum;
        logic [2:0]  mx;
        logic [9:0]  wce;
    } exp_t;

    typedef struct {
        int   mode;   // 0 identical, 1 exact=7/approx=0, 2 single bad vector at 600
        bit   mis;    // LAT2 instance fed through 1 register instead of 2
        int   mid;    // cycle of an extra start during the sweep (0 = none)
        bit   inj;    // extra start in u0's DONE cycle
        exp_t e0, e1, e2;
        int   d0, d3;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    int   mode = 0;
    bit   mis = 1'b0;
    int   nvec = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    logic [9:0]  pi0, pi2, pi3;
    logic [2:0]  ex0, ap0, ex2, ap2, ex3, ap3;
    logic [2:0]  d1e = '0, d1a = '0, d2e = '0, d2a = '0;
    logic        busy0, busy2, busy3, done0, done2, done3;
    logic [10:0] ec0, ec2, ec3;
    logic [12:0] sm0, sm2, sm3;
    logic [2:0]  mx0, mx2, mx3;
    logic [9:0]  wc0, wc2, wc3;

    function automatic logic [2:0] fe(int m, logic [9:0] v);
        return (m == 1) ? 3'd7 : 3'(v % 10'd7);
    endfunction

    function automatic logic [2:0] fa(int m, logic [9:0] v);
        if (m == 1) return 3'd0;
        if (m == 2 && v == 10'd600) return fe(m, v) ^ 3'b100;
        return fe(m, v);
    endfunction

    function automatic exp_t mk(int c, int s, int m, int w);
        exp_t r;
        r.cnt = 11'(c);
        r.sum = 13'(s);
        r.mx  = 3'(m);
        r.wce = 10'(w);
        return r;
    endfunction

    always_comb begin
        ex0 = fe(mode, pi0);
        ap0 = fa(mode, pi0);
        ex2 = fe(mode, pi2);
        ap2 = fa(mode, pi2);
    end

    // Two-register netlist model for the LAT2 instance.
    always_ff @(posedge clk) begin
        d1e <= fe(mode, pi3);
        d1a <= fa(mode, pi3);
        d2e <= d1e;
        d2a <= d1a;
    end
    assign ex3 = mis ? d1e : d2e;
    assign ap3 = mis ? d1a : d2a;

    sad_error_evaluator #(.N_IN(10), .N_OUT(3), .DUT_LAT(0), .ET(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .pi(pi0),
        .exact_po(ex0), .approx_po(ap0), .busy(busy0), .done(done0),
        .err_count(ec0), .sum_abs_err(sm0), .max_abs_err(mx0), .wce_vector(wc0));

    sad_error_evaluator #(.N_IN(10), .N_OUT(3), .DUT_LAT(0), .ET(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .pi(pi2),
        .exact_po(ex2), .approx_po(ap2), .busy(busy2), .done(done2),
        .err_count(ec2), .sum_abs_err(sm2), .max_abs_err(mx2), .wce_vector(wc2));

    sad_error_evaluator #(.N_IN(10), .N_OUT(3), .DUT_LAT(2), .ET(2)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start), .pi(pi3),
        .exact_po(ex3), .approx_po(ap3), .busy(busy3), .done(done3),
        .err_count(ec3), .sum_abs_err(sm3), .max_abs_err(mx3), .wce_vector(wc3));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_res(input string n, input logic [10:0] c, input logic [12:0] s,
                             input logic [2:0] m, input logic [9:0] w, input exp_t e);
        check({n, ".err_count"},   64'(c), 64'(e.cnt));
        check({n, ".sum_abs_err"}, 64'(s), 64'(e.sum));
        check({n, ".max_abs_err"}, 64'(m), 64'(e.mx));
        check({n, ".wce_vector"},  64'(w), 64'(e.wce));
    endtask

    vec_t tbl[5];

    task automatic run_row(input int i);
        int d0, d3, bc, dc;
        bit piok;
        mode = tbl[i].mode;
        mis  = tbl[i].mis;
        d0 = 0; d3 = 0; bc = 0; dc = 0; piok = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(posedge clk);                       // edge 0
        for (int c = 1; c <= 1200; c++) begin
            @(negedge clk);                   // inside cycle c
            if (busy0) begin
                bc++;
                if (pi0 != 10'(c - 1)) piok = 1'b0;
            end
            if (done0) dc++;
            if (done0 && d0 == 0) d0 = c;
            if (done3 && d3 == 0) d3 = c;
            start = (c == tbl[i].mid) || (tbl[i].inj && done0);
            if (d0 != 0 && d3 != 0) break;
        end
        start = 1'b0;
        check($sformatf("row%0d.done_cycle_lat0", i), 64'(d0), 64'(tbl[i].d0));
        check($sformatf("row%0d.done_cycle_lat2", i), 64'(d3), 64'(tbl[i].d3));
        check($sformatf("row%0d.busy_cycles", i),     64'(bc), 64'd1024);
        check($sformatf("row%0d.done_pulses", i),     64'(dc), 64'd1);
        check($sformatf("row%0d.pi_sequence", i),     64'(piok), 64'd1);
        check($sformatf("row%0d.idle_after", i),      64'(busy0), 64'd0);
        check_res($sformatf("row%0d.u0", i), ec0, sm0, mx0, wc0, tbl[i].e0);
        check_res($sformatf("row%0d.u2", i), ec2, sm2, mx2, wc2, tbl[i].e1);
        check_res($sformatf("row%0d.u3", i), ec3, sm3, mx3, wc3, tbl[i].e2);
    endtask

    initial begin
        exp_t z, full7, bad600;
        int dc;
        z      = mk(0, 0, 0, 0);
        full7  = mk(1024, 7168, 7, 0);
        bad600 = mk(1, 4, 4, 600);
        tbl[0] = '{mode: 0, mis: 1'b0, mid: 0,   inj: 1'b0, e0: z,      e1: z,      e2: z,                d0: 1025, d3: 1027};
        tbl[1] = '{mode: 1, mis: 1'b0, mid: 0,   inj: 1'b0, e0: full7,  e1: full7,  e2: full7,            d0: 1025, d3: 1027};
        tbl[2] = '{mode: 2, mis: 1'b0, mid: 0,   inj: 1'b0, e0: bad600, e1: bad600, e2: bad600,           d0: 1025, d3: 1027};
        // One-register feed: tag t meets the po of vector t+1, so 600 lands on tag 599.
        tbl[3] = '{mode: 2, mis: 1'b1, mid: 0,   inj: 1'b0, e0: bad600, e1: bad600, e2: mk(1, 4, 4, 599), d0: 1025, d3: 1027};
        tbl[4] = '{mode: 2, mis: 1'b0, mid: 300, inj: 1'b1, e0: bad600, e1: bad600, e2: bad600,           d0: 1025, d3: 1027};

        // Reset state.
        #12;
        check("reset.busy", 64'(busy0), 64'd0);
        check("reset.done", 64'(done0), 64'd0);
        check("reset.pi",   64'(pi0),   64'd0);
        check_res("reset.u0", ec0, sm0, mx0, wc0, z);
        check_res("reset.u3", ec3, sm3, mx3, wc3, z);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_row(i);

        // Reset in the middle of a sweep.
        mode = 1;
        mis  = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (499) @(negedge clk);          // inside cycle 500
        check("abort.sum_before", 64'(sm0), 64'd3493);   // 499 samples of 7
        #2 rst_n = 1'b0;
        #1;
        check("abort.busy",  64'(busy0), 64'd0);
        check("abort.done",  64'(done0), 64'd0);
        check("abort.pi",    64'(pi0),   64'd0);
        check("abort.busy3", 64'(busy3), 64'd0);
        check_res("abort.u0", ec0, sm0, mx0, wc0, z);
        check_res("abort.u3", ec3, sm3, mx3, wc3, z);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done0 || done3 || busy0) dc++;
        end
        check("abort.no_done", 64'(dc), 64'd0);
        run_row(1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
